// File: rtl/bmp_frame_ctrl.sv
// ----------------------------------------------------------------------------
// bmp_frame_ctrl
//   Frame sequencer between a show-ahead pixel FIFO and a BMP byte encoder.
//   A trigger (held in a 1-deep pending flag) starts the encoder once it is
//   ready; the encoder then pulls source bytes one at a time, B, G, R per
//   pixel, and the controller pops the FIFO after the R byte of each pixel.
//
//   Optional feature: define BMP_CTRL_TIMEOUT_EN to build the RUN-state
//   watchdog. Without it the ERR state is unreachable and timeout_o is 0.
//
// Ports
//   sys_clk_i       in   clock, rising edge
//   sys_rst_n_i     in   asynchronous active-low reset
//   frame_trig_i    in   request encoding of one frame (pulse)
//   pix_empty_i     in   pixel FIFO empty
//   pix_data_i      in   head-of-FIFO pixel {R,G,B}
//   pix_rd_o        out  FIFO pop, same cycle as the R-byte request
//   enc_ready_i     in   encoder idle/ready
//   enc_start_o     out  one-cycle encoder start
//   enc_src_req_i   in   encoder requests one source byte
//   enc_src_data_o  out  registered source byte (1-cycle latency)
//   enc_done_i      in   encoder frame complete
//   busy_o          out  high in any state except IDLE
//   frame_cnt_o     out  completed-frame counter (wraps)
//   underflow_o     out  sticky: byte requested while FIFO empty
//   timeout_o       out  encoder stalled (watchdog build only)
// ----------------------------------------------------------------------------
module bmp_frame_ctrl #(
    parameter logic [15:0] BMP_WIDTH   = 16'd8,
    parameter logic [15:0] BMP_HEIGHT  = 16'd8,
    parameter logic [31:0] TIMEOUT_CYC = 32'd4096
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_n_i,
    input  logic        frame_trig_i,
    input  logic        pix_empty_i,
    input  logic [23:0] pix_data_i,
    output logic        pix_rd_o,
    input  logic        enc_ready_i,
    output logic        enc_start_o,
    input  logic        enc_src_req_i,
    output logic [7:0]  enc_src_data_o,
    input  logic        enc_done_i,
    output logic        busy_o,
    output logic [15:0] frame_cnt_o,
    output logic        underflow_o,
    output logic        timeout_o
);

    localparam logic [31:0] PIX_TOTAL = {16'd0, BMP_WIDTH} * {16'd0, BMP_HEIGHT};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    logic        pending;
    logic [1:0]  byte_idx;
    logic [31:0] pix_cnt;
    logic        req_run;
    logic        frame_left;

    // Byte order inside a pixel: 0 = B, 1 = G, 2 = R.
    function automatic logic [7:0] sel_byte(input logic [23:0] px, input logic [1:0] idx);
        case (idx)
            2'd0:    sel_byte = px[7:0];
            2'd1:    sel_byte = px[15:8];
            default: sel_byte = px[23:16];
        endcase
    endfunction

    assign req_run    = (state == S_RUN) && enc_src_req_i;
    assign frame_left = (pix_cnt < PIX_TOTAL);

    // The pop must land in the request cycle so the show-ahead FIFO presents
    // the next pixel by the time the following B byte is requested.
    assign pix_rd_o = req_run && frame_left && (byte_idx == 2'd2) && !pix_empty_i;

`ifdef BMP_CTRL_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        timeout_q;
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state          <= S_IDLE;
            pending        <= 1'b0;
            byte_idx       <= 2'd0;
            pix_cnt        <= 32'd0;
            enc_start_o    <= 1'b0;
            enc_src_data_o <= 8'h00;
            busy_o         <= 1'b0;
            frame_cnt_o    <= 16'd0;
            underflow_o    <= 1'b0;
`ifdef BMP_CTRL_TIMEOUT_EN
            wd_cnt         <= 32'd0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            enc_start_o <= 1'b0;
            // Triggers merge into the single pending flag; the IDLE take
            // below overrides this so one trigger never yields two frames.
            if (frame_trig_i) begin
                pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (pending && enc_ready_i) begin
                        state   <= S_START;
                        pending <= 1'b0;
                        busy_o  <= 1'b1;
                    end
                end

                S_START: begin
                    state       <= S_RUN;
                    enc_start_o <= 1'b1;
                    byte_idx    <= 2'd0;
                    pix_cnt     <= 32'd0;
`ifdef BMP_CTRL_TIMEOUT_EN
                    wd_cnt      <= 32'd0;
`endif
                end

                S_RUN: begin
                    if (enc_src_req_i) begin
                        if (frame_left) begin
                            // Empty FIFO still advances the position so the
                            // byte stream stays aligned to pixel boundaries.
                            enc_src_data_o <= pix_empty_i ? 8'h00 : sel_byte(pix_data_i, byte_idx);
                            if (pix_empty_i) begin
                                underflow_o <= 1'b1;
                            end
                            if (byte_idx == 2'd2) begin
                                byte_idx <= 2'd0;
                                pix_cnt  <= pix_cnt + 32'd1;
                            end else begin
                                byte_idx <= byte_idx + 2'd1;
                            end
                        end else begin
                            enc_src_data_o <= 8'h00;
                        end
                    end
`ifdef BMP_CTRL_TIMEOUT_EN
                    wd_cnt <= enc_src_req_i ? 32'd0 : wd_cnt + 32'd1;
                    if (enc_done_i) begin
                        state <= S_DONE;
                    end else if (!enc_src_req_i && (wd_cnt + 32'd1 >= TIMEOUT_CYC)) begin
                        state     <= S_ERR;
                        timeout_q <= 1'b1;
                    end
`else
                    if (enc_done_i) begin
                        state <= S_DONE;
                    end
`endif
                end

                S_DONE: begin
                    frame_cnt_o <= frame_cnt_o + 16'd1;
                    state       <= S_IDLE;
                    busy_o      <= 1'b0;
                end

                S_ERR: begin
`ifdef BMP_CTRL_TIMEOUT_EN
                    if (frame_trig_i) begin
                        state     <= S_IDLE;
                        busy_o    <= 1'b0;
                        timeout_q <= 1'b0;
                    end
`else
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
`endif
                end

                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bmp_frame_ctrl.md
BMP_FRAME_CTRL -- requirements
Module: bmp_frame_ctrl

Interface
REQ-001 Parameter BMP_WIDTH, default 16'd8, image width in pixels.
REQ-002 Parameter BMP_HEIGHT, default 16'd8, image height in pixels.
REQ-003 Parameter TIMEOUT_CYC, default 32'd4096, max idle cycles between encoder requests in RUN.
REQ-004 sys_clk_i  in  1  single clock, all logic rising-edge.
REQ-005 sys_rst_n_i  in  1  asynchronous active-low reset.
REQ-006 frame_trig_i  in  1  pulse: request encoding of one frame.
REQ-007 pix_empty_i  in  1  pixel FIFO empty (show-ahead FIFO).
REQ-008 pix_data_i  in  24  head-of-FIFO pixel {R[23:16],G[15:8],B[7:0]}.
REQ-009 pix_rd_o  out  1  one-cycle FIFO pop.
REQ-010 enc_ready_i  in  1  encoder idle/ready.
REQ-011 enc_start_o  out  1  one-cycle encoder start.
REQ-012 enc_src_req_i  in  1  encoder requests one source byte.
REQ-013 enc_src_data_o  out  8  registered source byte.
REQ-014 enc_done_i  in  1  encoder frame complete.
REQ-015 busy_o  out  1  high in any state except IDLE.
REQ-016 frame_cnt_o  out  16  completed-frame counter.
REQ-017 underflow_o  out  1  sticky: byte requested while FIFO empty.
REQ-018 timeout_o  out  1  encoder stalled (see Configuration).

Function
REQ-019 States IDLE, START, RUN, DONE, ERR; encoding one-hot or binary is free.
REQ-020 frame_trig_i in any state sets a 1-deep pending flag; multiple triggers while pending merge into one.
REQ-021 IDLE -> START when pending && enc_ready_i; pending clears on that transition.
REQ-022 START: enc_start_o=1 for exactly one cycle; byte_idx, pix_cnt cleared; next state RUN.
REQ-023 RUN: each cycle with enc_src_req_i, enc_src_data_o updates next cycle (1-cycle latency) to byte byte_idx of pix_data_i: 0=B, 1=G, 2=R.
REQ-024 byte_idx increments per request, wraps 2->0; on wrap pix_cnt increments and pix_rd_o=1 in the same cycle as the request, only if !pix_empty_i.
REQ-025 Request with pix_empty_i=1: enc_src_data_o=8'h00, underflow_o set, byte_idx/pix_cnt still advance, no pop.
REQ-026 Requests after pix_cnt reaches BMP_WIDTH*BMP_HEIGHT: data 8'h00, no pop, no counter change; pix_cnt width 32 bits.
REQ-027 RUN -> DONE on enc_done_i; DONE lasts one cycle, frame_cnt_o increments (wraps 16'hFFFF->0), then IDLE.
REQ-028 enc_done_i and timeout in the same cycle: done wins, go to DONE.
REQ-029 enc_done_i, enc_src_req_i outside RUN are ignored (no pop, data unchanged).
REQ-030 ERR: timeout_o=1; exits to IDLE on frame_trig_i (which is also recorded as pending).
REQ-031 underflow_o clears only on reset.

Reset
REQ-032 Reset asserted, any state, mid-frame included: state IDLE, pending 0, all outputs 0, frame_cnt_o 0, counters 0.
REQ-033 Reset deassertion takes effect on the first rising edge after release; no output glitches to 1 during reset.

Configuration
REQ-034 Macro BMP_CTRL_TIMEOUT_EN defined: watchdog counts RUN cycles since last enc_src_req_i or START; reaching TIMEOUT_CYC moves RUN -> ERR.
REQ-035 Macro undefined: no watchdog logic, ERR unreachable, timeout_o tied 0.

Verification (BMP_WIDTH=2, BMP_HEIGHT=2, TIMEOUT_CYC=16)
REQ-036 FIFO holds 4 pixels 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF, trigger, encoder issues 12 requests -> bytes 00,00,FF,00,FF,00,FF,00,00,FF,FF,FF, 4 pops, frame_cnt_o=1.
REQ-037 Trigger with enc_ready_i=0 for 10 cycles then 1 -> enc_start_o single pulse 2 cycles after ready rises, busy_o high from START.
REQ-038 FIFO empty, 3 requests -> three 8'h00 bytes, underflow_o=1 and stays 1 after DONE, no pops.
REQ-039 With BMP_CTRL_TIMEOUT_EN, no requests for 16 RUN cycles -> ERR, timeout_o=1; trigger -> IDLE then START; without macro, no ERR.
REQ-040 Reset pulsed after 5 of 12 bytes -> all outputs 0, next trigger starts fresh with byte B of FIFO head pixel.
REQ-041 Two triggers during RUN -> exactly one further frame runs after DONE, frame_cnt_o=2.
